param_up_down_counter: RTL and testbench
========================================

PARAM_UP_DOWN_COUNTER -- requirements
Module: param_up_down_counter

Interface
REQ-001 Parameter: WIDTH, 8, counter width in bits; legal range 2..32.
REQ-002 Parameter: MAX_VAL, 2**WIDTH-1, terminal count (modulus-1); legal range 1..2**WIDTH-1.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: en  input  1  count enable; no step when low.
REQ-006 Port: load  input  1  parallel load strobe.
REQ-007 Port: up_down  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 Port: sat_mode  input  1  boundary mode: 1 = saturate, 0 = wrap.
REQ-009 Port: data_in  input  WIDTH  load value.
REQ-010 Port: cmp_val  input  WIDTH  compare value.
REQ-011 Port: count_out  output  WIDTH  current count, registered.
REQ-012 Port: ovf  output  1  registered one-cycle pulse: up-step attempted at MAX_VAL.
REQ-013 Port: unf  output  1  registered one-cycle pulse: down-step attempted at 0.
REQ-014 Port: at_max  output  1  combinational, count_out == MAX_VAL.
REQ-015 Port: at_zero  output  1  combinational, count_out == 0.
REQ-016 Port: match  output  1  combinational, count_out == cmp_val.

Function
REQ-017 Per-edge priority SHALL be: reset > load > en; inputs sampled at the rising edge of clk.
REQ-018 load=1 SHALL set count_out to data_in, clamped to MAX_VAL when data_in > MAX_VAL, irrespective of en and up_down.
REQ-019 en=1, load=0, up_down=1, count_out < MAX_VAL SHALL increment count_out by 1.
REQ-020 en=1, load=0, up_down=0, count_out > 0 SHALL decrement count_out by 1.
REQ-021 Up-step at MAX_VAL SHALL give count_out 0 when sat_mode=0 and hold MAX_VAL when sat_mode=1; ovf SHALL be 1 in the following cycle in both modes.
REQ-022 Down-step at 0 SHALL give count_out MAX_VAL when sat_mode=0 and hold 0 when sat_mode=1; unf SHALL be 1 in the following cycle in both modes.
REQ-023 ovf and unf SHALL be 0 in every cycle not following a boundary step; never both 1; never asserted by load.
REQ-024 en=0 and load=0 SHALL hold count_out; sat_mode and up_down changes alone SHALL not alter count_out.
REQ-025 count_out SHALL never exceed MAX_VAL; arithmetic modulo MAX_VAL+1, no intermediate overflow for MAX_VAL = 2**WIDTH-1.
REQ-026 Counting latency SHALL be one clock: a step sampled at edge N appears on count_out after edge N.
REQ-027 at_max, at_zero, match SHALL be purely combinational from count_out (and cmp_val); no added latency.

Reset
REQ-028 reset=1 at a rising edge SHALL set count_out=0, ovf=0, unf=0, overriding load and en.
REQ-029 Reset asserted mid-count SHALL take effect at that edge; first step after release occurs on the first edge with reset=0.
REQ-030 Outputs SHALL be undefined only before the first reset edge; no asynchronous behaviour.

Configuration
REQ-031 Macro UDC_WRAP_CNT_EN defined SHALL add output port wrap_cnt (output, 16 bits): count of ovf+unf events, incremented in the cycle the pulse is asserted, saturating at 16'hFFFF, cleared only by reset.
REQ-032 Macro UDC_WRAP_CNT_EN undefined SHALL omit wrap_cnt and its logic; all other behaviour identical.

Verification (WIDTH=4, MAX_VAL=9)
REQ-033 reset=1 while load=1, data_in=5 -> count_out=0, ovf=0, unf=0 next cycle.
REQ-034 load data_in=7, then en=1 up_down=1 sat_mode=0 for 3 cycles -> 8, 9, 0; ovf=1 exactly in the cycle count_out shows 0; at_max=1 while 9.
REQ-035 count=0, en=1 up_down=0 sat_mode=1 for 2 cycles -> count stays 0, unf=1 for 2 cycles, at_zero=1.
REQ-036 load data_in=15 -> count_out=9 (clamped), ovf=0; cmp_val=9 -> match=1.
REQ-037 count=4, load=1 data_in=2 with en=1 up_down=1 same edge -> count_out=2; then en=0 for 5 cycles -> holds 2.
REQ-038 UDC_WRAP_CNT_EN defined: 25 wrap-mode up-steps from 0 -> count_out=5, wrap_cnt=2; reset -> wrap_cnt=0.

Source files
------------

// File: rtl/param_up_down_counter.sv
// rtl/param_up_down_counter.sv - modulo-(MAX_VAL+1) up/down counter with load, saturate/wrap and boundary pulses
// Optional 16-bit wrap event counter on port wrap_cnt when UDC_WRAP_CNT_EN is defined.
module param_up_down_counter #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic             up_down,
   input  logic             sat_mode,
   input  logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] cmp_val,
   output logic [WIDTH-1:0] count_out,
   output logic             ovf,
   output logic             unf,
   output logic             at_max,
   output logic             at_zero,
   output logic             match
`ifdef UDC_WRAP_CNT_EN
   ,
   output logic [15:0]      wrap_cnt
`endif
);

   logic [WIDTH-1:0] count_nxt;
   logic             ovf_nxt;
   logic             unf_nxt;

   assign at_max  = (count_out == MAX_VAL);
   assign at_zero = (count_out == '0);
   assign match   = (count_out == cmp_val);

   // Boundary steps are detected on the current count, so no wider adder is needed.
   always_comb begin
      count_nxt = count_out;
      ovf_nxt   = 1'b0;
      unf_nxt   = 1'b0;
      if (load) begin
         count_nxt = (data_in > MAX_VAL) ? MAX_VAL : data_in;
      end else if (en) begin
         if (up_down) begin
            if (at_max) begin
               ovf_nxt   = 1'b1;
               count_nxt = sat_mode ? MAX_VAL : '0;
            end else begin
               count_nxt = count_out + WIDTH'(1);
            end
         end else begin
            if (at_zero) begin
               unf_nxt   = 1'b1;
               count_nxt = sat_mode ? '0 : MAX_VAL;
            end else begin
               count_nxt = count_out - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_out <= '0;
         ovf       <= 1'b0;
         unf       <= 1'b0;
      end else begin
         count_out <= count_nxt;
         ovf       <= ovf_nxt;
         unf       <= unf_nxt;
      end
   end

`ifdef UDC_WRAP_CNT_EN
   // Counts at the same edge that raises ovf/unf, so the total is visible alongside the pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrap_cnt <= '0;
      end else if ((ovf_nxt || unf_nxt) && (wrap_cnt != 16'hFFFF)) begin
         wrap_cnt <= wrap_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_param_up_down_counter.sv
// tb/tb_param_up_down_counter.sv - randomized and directed check of param_up_down_counter (WIDTH=4, MAX_VAL=9)
module tb_param_up_down_counter;

   localparam int W   = 4;
   localparam int MAX = 9;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         en = 1'b0;
   logic         load = 1'b0;
   logic         up_down = 1'b0;
   logic         sat_mode = 1'b0;
   logic [W-1:0] data_in = '0;
   logic [W-1:0] cmp_val = '0;
   logic [W-1:0] count_out;
   logic         ovf, unf, at_max, at_zero, match;
`ifdef UDC_WRAP_CNT_EN
   logic [15:0]  wrap_cnt;
   int           m_wrap = 0;
`endif

   int checks = 0;
   int errors = 0;
   int m_cnt = 0;
   int m_ovf = 0;
   int m_unf = 0;

   param_up_down_counter #(.WIDTH(W), .MAX_VAL(4'd9)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .load     (load),
      .up_down  (up_down),
      .sat_mode (sat_mode),
      .data_in  (data_in),
      .cmp_val  (cmp_val),
      .count_out(count_out),
      .ovf      (ovf),
      .unf      (unf),
      .at_max   (at_max),
      .at_zero  (at_zero),
      .match    (match)
`ifdef UDC_WRAP_CNT_EN
      ,
      .wrap_cnt (wrap_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference behaviour expressed as modular arithmetic on an integer count.
   task automatic model_edge();
      int was;
      was   = m_cnt;
      m_ovf = 0;
      m_unf = 0;
      if (reset) begin
         m_cnt = 0;
`ifdef UDC_WRAP_CNT_EN
         m_wrap = 0;
`endif
      end else if (load) begin
         m_cnt = (int'(data_in) > MAX) ? MAX : int'(data_in);
      end else if (en) begin
         if (up_down) begin
            m_ovf = (was == MAX);
            m_cnt = (m_ovf && sat_mode) ? was : (was + 1) % (MAX + 1);
         end else begin
            m_unf = (was == 0);
            m_cnt = (m_unf && sat_mode) ? was : (was + MAX) % (MAX + 1);
         end
      end
`ifdef UDC_WRAP_CNT_EN
      if ((m_ovf || m_unf) && m_wrap < 65535) m_wrap++;
`endif
   endtask

   task automatic check_all(input string tag);
      check({tag, "_cnt"},  32'(count_out), 32'(m_cnt));
      check({tag, "_ovf"},  32'(ovf),       32'(m_ovf));
      check({tag, "_unf"},  32'(unf),       32'(m_unf));
      check({tag, "_max"},  32'(at_max),    32'(m_cnt == MAX));
      check({tag, "_zero"}, 32'(at_zero),   32'(m_cnt == 0));
      check({tag, "_match"},32'(match),     32'(m_cnt == int'(cmp_val)));
`ifdef UDC_WRAP_CNT_EN
      check({tag, "_wrap"}, 32'(wrap_cnt),  32'(m_wrap));
`endif
   endtask

   task automatic step(input string tag, input logic r, input logic l, input logic e,
                       input logic ud, input logic sm, input logic [W-1:0] d);
      reset = r; load = l; en = e; up_down = ud; sat_mode = sm; data_in = d;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      // reset wins over a simultaneous load
      step("rst_load", 1, 1, 1, 1, 0, 4'd5);
      check("rst_cnt0", 32'(count_out), 32'd0);

      // wrap-mode up-count through the terminal value
      step("ld7", 0, 1, 0, 0, 0, 4'd7);
      step("up8", 0, 0, 1, 1, 0, 4'd0);
      step("up9", 0, 0, 1, 1, 0, 4'd0);
      check("at_max_9", 32'(at_max), 32'd1);
      step("up0", 0, 0, 1, 1, 0, 4'd0);
      check("ovf_on_wrap", 32'(ovf), 32'd1);
      check("wrap_to_0", 32'(count_out), 32'd0);

      // saturating down-steps at zero pulse unf every attempt
      step("dsat1", 0, 0, 1, 0, 1, 4'd0);
      check("unf_sat1", 32'(unf), 32'd1);
      step("dsat2", 0, 0, 1, 0, 1, 4'd0);
      check("unf_sat2", 32'(unf), 32'd1);
      check("zero_sat", 32'(at_zero), 32'd1);

      // wrap-mode down-step at zero
      step("dwrap", 0, 0, 1, 0, 0, 4'd0);
      check("dwrap_max", 32'(count_out), 32'd9);

      // clamped load, no pulse
      cmp_val = 4'd9;
      step("ld15", 0, 1, 0, 1, 0, 4'd15);
      check("clamp9", 32'(count_out), 32'd9);
      check("clamp_no_ovf", 32'(ovf), 32'd0);
      check("clamp_match", 32'(match), 32'd1);
      cmp_val = 4'd3;
      #1;
      check("match_comb", 32'(match), 32'd0);

      // load beats enable; then hold while direction/mode toggle
      step("ld4", 0, 1, 0, 0, 0, 4'd4);
      step("ld2_en", 0, 1, 1, 1, 0, 4'd2);
      check("ld_over_en", 32'(count_out), 32'd2);
      for (int i = 0; i < 5; i++) step("hold", 0, 0, 0, W'(i) != 0, i[0], 4'd0);
      check("held2", 32'(count_out), 32'd2);

      // mid-count reset, then counting resumes on first released edge
      step("up3", 0, 0, 1, 1, 0, 4'd0);
      step("midrst", 1, 0, 1, 1, 0, 4'd0);
      step("post_rst", 0, 0, 1, 1, 0, 4'd0);
      check("post_rst1", 32'(count_out), 32'd1);

`ifdef UDC_WRAP_CNT_EN
      step("wrst", 1, 0, 0, 0, 0, 4'd0);
      for (int i = 0; i < 25; i++) step("wup", 0, 0, 1, 1, 0, 4'd0);
      check("w25_cnt", 32'(count_out), 32'd5);
      check("w25_wrap", 32'(wrap_cnt), 32'd2);
      step("wclr", 1, 0, 0, 0, 0, 4'd0);
      check("wrap_clr", 32'(wrap_cnt), 32'd0);
`endif

      // random sweep against the model
      for (int i = 0; i < 400; i++) begin
         cmp_val = W'($urandom_range(0, 15));
         step("rnd", $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, W'($urandom_range(0, 15)));
         check("rnd_excl", 32'(ovf & unf), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
